fifo_cmd_unpack: RTL

FIFO_CMD_UNPACK -- requirements
Module: fifo_cmd_unpack

---
 rtl/multiexp_pkg.sv | 32 +++
 rtl/fifo_word_asm.sv | 74 +++++++
 rtl/fifo_cmd_unpack.sv | 125 ++++++++++++
 3 files changed

// File: rtl/multiexp_pkg.sv
// Shared header layout, opcodes and FSM states for the host command unpacker.
// Header word: [31:24] opcode, [23:16] reserved (zero), [15:0] operand count.
package multiexp_pkg;

  localparam int HDR_OP_LSB  = 24;
  localparam int HDR_RSV_LSB = 16;
  localparam int HDR_CNT_LSB = 0;

  localparam logic [7:0] OP_LOAD = 8'h01;
  localparam logic [7:0] OP_EXP  = 8'h05;

  typedef enum logic [2:0] {
    HDR_RD,
    HDR_WAIT,
    CMD_OUT,
    PAYLOAD,
    ERROR
  } state_t;

  function automatic logic [7:0] hdr_op(input logic [31:0] w);
    return w[HDR_OP_LSB +: 8];
  endfunction

  function automatic logic [7:0] hdr_rsv(input logic [31:0] w);
    return w[HDR_RSV_LSB +: 8];
  endfunction

  function automatic logic [15:0] hdr_cnt(input logic [31:0] w);
    return w[HDR_CNT_LSB +: 16];
  endfunction

endpackage

// File: rtl/fifo_word_asm.sv
// Packs 32-bit words into n_words-wide operands behind a valid/ready output.
// Ports: i_wr/i_wdata word in, i_last tag, i_ready/o_valid/o_data/o_last out,
// o_move (operand moved to output), o_room (another read may be issued).
module fifo_word_asm
  import multiexp_pkg::*;
#(
  parameter int n_words = 8
) (
  input  logic                   clk,
  input  logic                   aclr,
  input  logic                   i_wr,
  input  logic [31:0]            i_wdata,
  input  logic                   i_last,
  input  logic                   i_ready,
  output logic                   o_move,
  output logic                   o_room,
  output logic                   o_valid,
  output logic [32*n_words-1:0]  o_data,
  output logic                   o_last
);

  localparam int FW = $clog2(n_words + 1);
  localparam int IW = $clog2(n_words);
  localparam logic [FW-1:0] FULL = FW'(n_words);

  logic [FW-1:0]               r_fill;
  logic [n_words-1:0][31:0]    r_buf;
  logic [n_words-1:0][31:0]    w_img;
  logic [32*n_words-1:0]       r_data;
  logic                        r_valid;
  logic                        r_last;
  logic [FW-1:0]               w_cnt;
  logic [FW-1:0]               w_next;
  logic [IW-1:0]               w_idx;

  // w_cnt counts the word landing this cycle, so the final word of an
  // operand goes straight to the output and reads never bubble.
  assign w_idx  = r_fill[IW-1:0];
  assign w_cnt  = r_fill + FW'(i_wr);
  assign o_move = (w_cnt == FULL) && (!r_valid || i_ready);
  assign w_next = o_move ? '0 : w_cnt;
  assign o_room = w_next < FULL;

  always_comb begin
    w_img = r_buf;
    if (i_wr) w_img[w_idx] = i_wdata;
  end

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      r_fill  <= '0;
      r_buf   <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end else begin
      r_fill <= w_next;
      r_buf  <= w_img;
      if (o_move) begin
        r_data  <= w_img;
        r_last  <= i_last;
        r_valid <= 1'b1;
      end else if (i_ready) begin
        r_valid <= 1'b0;
        r_last  <= 1'b0;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_last  = r_last;

endmodule

// File: rtl/fifo_cmd_unpack.sv
// Reads header+payload commands from a non-showahead host FIFO.
// Ports: fifo_* read side, cmd_* header handshake, data_* operands, err.
module fifo_cmd_unpack
  import multiexp_pkg::*;
#(
  parameter int n_words     = 8,
  parameter int fifo_widthu = 11
) (
  input  logic                   clk,
  input  logic                   aclr,
  input  logic [31:0]            fifo_datai,
  input  logic                   fifo_empty,
  output logic                   fifo_rden,
  output logic                   cmd_valid,
  input  logic                   cmd_ready,
  output logic [7:0]             cmd_op,
  output logic [15:0]            cmd_count,
  output logic                   data_valid,
  input  logic                   data_ready,
  output logic [32*n_words-1:0]  data_out,
  output logic                   data_last,
  output logic                   err
);

  if (n_words < 2 || n_words > 64 || fifo_widthu < 1) begin : g_bad_param
    $error("fifo_cmd_unpack: parameter out of range");
  end

  localparam int REQW = 23;

  state_t             r_state;
  logic               r_cmd_valid;
  logic [7:0]         r_op;
  logic [15:0]        r_cnt;
  logic [REQW-1:0]    r_req_left;
  logic               r_inflight;
  logic [15:0]        r_opn;
  logic               r_err;

  logic w_room;
  logic w_move;
  logic w_last;
  logic w_last_hs;
  logic w_hdr_rd;
  logic w_pay_rd;

  // Read strobe is combinational on fifo_empty so a read can issue every
  // cycle; it is held off while aclr is asserted.
  assign w_last_hs = data_valid && data_ready && data_last;
  assign w_hdr_rd  = !aclr && !fifo_empty &&
                     ((r_state == HDR_RD) ||
                      (r_state == PAYLOAD && w_last_hs));
  assign w_pay_rd  = !aclr && !fifo_empty && (r_state == PAYLOAD) &&
                     (r_req_left != '0) && w_room;
  assign fifo_rden = w_hdr_rd || w_pay_rd;
  assign w_last    = (r_opn + 16'd1) == r_cnt;

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      r_state     <= HDR_RD;
      r_cmd_valid <= 1'b0;
      r_op        <= '0;
      r_cnt       <= '0;
      r_req_left  <= '0;
      r_inflight  <= 1'b0;
      r_opn       <= '0;
      r_err       <= 1'b0;
    end else begin
      r_inflight <= w_pay_rd;
      unique case (r_state)
        HDR_RD: begin
          if (w_hdr_rd) r_state <= HDR_WAIT;
        end
        HDR_WAIT: begin
          if (hdr_rsv(fifo_datai) != 8'h00) begin
            r_err   <= 1'b1;
            r_state <= ERROR;
          end else begin
            r_op        <= hdr_op(fifo_datai);
            r_cnt       <= hdr_cnt(fifo_datai);
            r_cmd_valid <= 1'b1;
            r_state     <= CMD_OUT;
          end
        end
        CMD_OUT: begin
          if (cmd_ready) begin
            r_cmd_valid <= 1'b0;
            r_req_left  <= REQW'(r_cnt) * REQW'(n_words);
            r_opn       <= '0;
            r_state     <= (r_cnt == '0) ? HDR_RD : PAYLOAD;
          end
        end
        PAYLOAD: begin
          if (w_pay_rd) r_req_left <= r_req_left - REQW'(1);
          if (w_move) r_opn <= r_opn + 16'd1;
          if (w_last_hs) r_state <= w_hdr_rd ? HDR_WAIT : HDR_RD;
        end
        ERROR: begin
          r_err <= 1'b1;
        end
        default: r_state <= ERROR;
      endcase
    end
  end

  fifo_word_asm #(.n_words(n_words)) u_asm (
    .clk     (clk),
    .aclr    (aclr),
    .i_wr    (r_inflight),
    .i_wdata (fifo_datai),
    .i_last  (w_last),
    .i_ready (data_ready),
    .o_move  (w_move),
    .o_room  (w_room),
    .o_valid (data_valid),
    .o_data  (data_out),
    .o_last  (data_last)
  );

  assign cmd_valid = r_cmd_valid;
  assign cmd_op    = r_op;
  assign cmd_count = r_cnt;
  assign err       = r_err;

endmodule
